count_tick_ctrl: RTL and testbench
==================================

// Module: count_tick_ctrl
// PURPOSE
//  Push-button sequencer for the up-counter datapath: replaces a free-running slow clock with a
//  one-cycle count-enable (tick) so the counter runs on the board clock. Buttons select
//  run/pause, single-step and one of four tick rates. Sits between the raw board buttons and
//  the counter's enable input.
// PARAMETERS
//  DIV0      2_500_000   rate 0 tick period, clk cycles (>=2)
//  DIV1      5_000_000   rate 1 tick period (reset rate)
//  DIV2      10_000_000  rate 2 tick period
//  DIV3      25_000_000  rate 3 tick period
//  DB_CYCLES 1_000_000   debounce stability window, clk cycles (>=2)
//  CNT_W     27          divider counter width; must hold max(DIVn)-1
// PORTS
//  clk       in   1  board clock
//  rst       in   1  synchronous active-high reset
//  btn_run   in   1  raw button, toggles RUN/PAUSE
//  btn_step  in   1  raw button, one tick when not running
//  btn_rate  in   1  raw button, cycles rate_sel
//  tick      out  1  count enable, one clk cycle high per tick
//  state     out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 STEP
//  rate_sel  out  2  active rate index
// BEHAVIOUR
//  Reset (sync, rst high at posedge): state=IDLE, rate_sel=1, div_cnt=0, tick=0, sync FFs=0,
//   debounced levels=0, debounce counters=0. rst overrides every other event; mid-run reset
//   drops any pending tick.
//  Input conditioning (per button, independent): 2-FF synchroniser -> debouncer. If sync!=db:
//   db_cnt++; on db_cnt==DB_CYCLES-1: db<=sync, db_cnt<=0. If sync==db: db_cnt<=0.
//   press = db & ~db_d (one-cycle pulse on debounced rising edge; release gives no pulse).
//   Latency raw rise -> press pulse: 2 + DB_CYCLES + 1 cycles. Glitches shorter than window ignored.
//  FSM (on press pulses; priority run_press > step_press):
//   IDLE : run_press -> RUN; step_press -> STEP.
//   RUN  : run_press -> PAUSE; step_press ignored.
//   PAUSE: run_press -> RUN; step_press -> STEP.
//   STEP : unconditionally -> PAUSE next cycle; presses this cycle dropped.
//  Divider (div_cnt), DIV = DIV[rate_sel]:
//   RUN: div_cnt==DIV-1 -> div_cnt<=0, tick<=1; else div_cnt++, tick<=0. First tick in RUN
//    from div_cnt=0 appears DIV cycles after RUN entry.
//   IDLE/PAUSE/STEP: div_cnt holds (PAUSE->RUN resumes mid-period); IDLE holds 0.
//  Step tick: edge entering STEP sets tick<=1, so tick is high exactly during the STEP cycle;
//   div_cnt unaffected.
//  tick is registered; never high two consecutive cycles except DIV... (DIV>=2 forbids it).
//  Rate: rate_press -> rate_sel<=rate_sel+1 mod 4 (3 wraps to 0), in any state, concurrent
//   with FSM events; same edge forces div_cnt<=0 and tick<=0 even if terminal count reached
//   (a simultaneous step tick still fires).
//  Simultaneous run+step in PAUSE: RUN entered, no step tick.
// TESTING (bench params DIV0..3=3,5,8,10, DB_CYCLES=4)
//  Reset: assert rst 2 cycles -> state=00, rate_sel=01, tick=0; check no tick for 50 cycles.
//  Debounce: btn_run pulse 3 cycles -> no state change; hold 10 cycles -> state=01 exactly
//   7 cycles after raw rise (2+4+1).
//  Run rate: RUN at rate 1 -> ticks spaced exactly 5 cycles; press rate -> next tick 8 cycles
//   after the rate edge, spacing 8; four presses wrap rate_sel 3->0, spacing 3.
//  Pause/resume: pause after div_cnt=2 at rate 1 -> no ticks for 100 cycles; resume -> first
//   tick 3 cycles after RUN entry.
//  Step: in PAUSE press step 3 times (spaced) -> exactly 3 single-cycle ticks, state 11 one
//   cycle each then 10; step in RUN -> tick spacing unchanged.
//  Collisions: run+step debounced same cycle in PAUSE -> state=01, no extra tick; rst asserted
//   cycle before terminal count -> tick stays 0, state=00.

Source files
------------

// File: rtl/count_tick_ctrl.sv
// rtl/count_tick_ctrl.sv - push-button run/pause/step/rate sequencer producing a one-cycle count-enable tick
module count_tick_ctrl #(
    parameter int DIV0      = 2_500_000,
    parameter int DIV1      = 5_000_000,
    parameter int DIV2      = 10_000_000,
    parameter int DIV3      = 25_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_rate,
    output logic       tick,
    output logic [1:0] state,
    output logic [1:0] rate_sel
);

    localparam int DB_W = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    state_t             cur_state;
    state_t             next_state;
    logic [2:0]         btn_raw;
    logic [2:0]         sync_a;
    logic [2:0]         sync_b;
    logic [2:0]         db;
    logic [2:0]         db_d;
    logic [2:0]         press;
    logic [DB_W-1:0]    db_cnt [3];
    logic               run_press;
    logic               step_press;
    logic               rate_press;
    logic [CNT_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   div_nxt;
    logic [CNT_W-1:0]   div_last;
    logic               tick_nxt;
    logic [1:0]         rate_nxt;

    // Bit 0 run, bit 1 step, bit 2 rate; each lane is conditioned independently.
    assign btn_raw = {btn_rate, btn_step, btn_run};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            db     <= '0;
            db_d   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            db_d   <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] != db[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        db[i]     <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press      = db & ~db_d;
    assign run_press  = press[0];
    assign step_press = press[1];
    assign rate_press = press[2];

    always_comb begin
        div_last = CNT_W'(DIV1 - 1);
        case (rate_sel)
            2'd0:    div_last = CNT_W'(DIV0 - 1);
            2'd1:    div_last = CNT_W'(DIV1 - 1);
            2'd2:    div_last = CNT_W'(DIV2 - 1);
            default: div_last = CNT_W'(DIV3 - 1);
        endcase
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE, S_PAUSE: begin
                if (run_press) begin
                    next_state = S_RUN;
                end else if (step_press) begin
                    next_state = S_STEP;
                end
            end
            S_RUN: begin
                if (run_press) begin
                    next_state = S_PAUSE;
                end
            end
            S_STEP:  next_state = S_PAUSE;
            default: next_state = S_IDLE;
        endcase
    end

    // A rate change restarts the period and swallows a coinciding terminal-count tick,
    // but the step tick is applied last so it always fires.
    always_comb begin
        div_nxt  = div_cnt;
        tick_nxt = 1'b0;
        rate_nxt = rate_sel;
        if (cur_state == S_RUN) begin
            if (div_cnt == div_last) begin
                div_nxt  = '0;
                tick_nxt = 1'b1;
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end
        if (rate_press) begin
            div_nxt  = '0;
            tick_nxt = 1'b0;
            rate_nxt = rate_sel + 2'd1;
        end
        if (next_state == S_STEP) begin
            tick_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            rate_sel  <= 2'd1;
            div_cnt   <= '0;
            tick      <= 1'b0;
        end else begin
            cur_state <= next_state;
            rate_sel  <= rate_nxt;
            div_cnt   <= div_nxt;
            tick      <= tick_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_count_tick_ctrl.sv
// tb/tb_count_tick_ctrl.sv - self-checking bench for count_tick_ctrl
module tb_count_tick_ctrl;

    localparam int DIV0 = 3;
    localparam int DIV1 = 5;
    localparam int DIV2 = 8;
    localparam int DIV3 = 10;
    localparam int DB   = 4;
    localparam int LAT  = 2 + DB + 1;

    localparam int K_START = 0;
    localparam int K_STOP  = 1;
    localparam int K_RATE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_rate = 1'b0;
    logic       tick;
    logic [1:0] state;
    logic [1:0] rate_sel;

    count_tick_ctrl #(
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3),
        .DB_CYCLES(DB), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_step(btn_step), .btn_rate(btn_rate),
        .tick(tick), .state(state), .rate_sel(rate_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  r;
        logic  s;
        logic  t;
        int    hold;
        int    s7;
        int    s8;
        int    rate;
        logic  tk;
    } vec_t;

    vec_t vt [15];
    int   exp_q [$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   ticks_seen = 0;
    bit   run_sched = 1'b0;
    int   next_tick = 0;
    int   period = DIV1;
    int   chg_edge = -1;
    int   chg_kind = K_START;
    int   chg_first = 0;
    int   chg_period = 0;
    int   remain = 0;

    function automatic vec_t mk(input string n, input logic r, input logic s, input logic t,
                                input int h, input int s7, input int s8, input int rt,
                                input logic tk);
        vec_t v;
        v.name = n; v.r = r; v.s = s; v.t = t; v.hold = h;
        v.s7 = s7; v.s8 = s8; v.rate = rt; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected ticks are pushed just before the edge they are due on; the tick seen
    // after each edge is matched against the queue head.
    task automatic cycle();
        int e;
        e = cyc + 1;
        if (chg_edge == e && chg_kind == K_RATE) begin
            next_tick = e + chg_first;
            period    = chg_period;
            chg_edge  = -1;
        end else begin
            if (run_sched && next_tick == e) begin
                exp_q.push_back(e);
                next_tick += period;
            end
            if (chg_edge == e) begin
                if (chg_kind == K_STOP) begin
                    run_sched = 1'b0;
                    remain    = next_tick - e;
                end else begin
                    run_sched = 1'b1;
                    next_tick = e + chg_first;
                    period    = chg_period;
                end
                chg_edge = -1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (tick) begin
            ticks_seen++;
            nvec++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                void'(exp_q.pop_front());
            end else begin
                nerr++;
                $display("FAIL tick: got 1, want 0 (cycle %0d)", cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
            nvec++;
            nerr++;
            $display("FAIL tick: got 0, want 1 (due cycle %0d, now %0d)", exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic press(input logic r, input logic s, input logic t,
                         input int s6, input int s7, input int s8);
        btn_run = r; btn_step = s; btn_rate = t;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (c == 10) begin
                btn_run = 1'b0; btn_step = 1'b0; btn_rate = 1'b0;
            end
            if (c == LAT - 1) chk("state_before_press", int'(state), s6);
            if (c == LAT)     chk("state_at_press", int'(state), s7);
            if (c == LAT + 1) chk("state_after_press", int'(state), s8);
        end
    endtask

    task automatic set_chg(input int kind, input int first, input int per);
        chg_edge   = cyc + LAT;
        chg_kind   = kind;
        chg_first  = first;
        chg_period = per;
    endtask

    task automatic rate_in_run(input int per, input int exp_rate);
        set_chg(K_RATE, per, per);
        press(1'b0, 1'b0, 1'b1, 1, 1, 1);
        chk("rate_sel_run", int'(rate_sel), exp_rate);
        repeat (25) cycle();
    endtask

    initial begin
        int k;
        int bound;

        vt[0]  = mk("run_glitch",  1, 0, 0, 3,  0, 0, 1, 0);
        vt[1]  = mk("step_glitch", 0, 1, 0, 3,  0, 0, 1, 0);
        vt[2]  = mk("rate_glitch", 0, 0, 1, 3,  0, 0, 1, 0);
        vt[3]  = mk("rate_a",      0, 0, 1, 10, 0, 0, 2, 0);
        vt[4]  = mk("rate_b",      0, 0, 1, 10, 0, 0, 3, 0);
        vt[5]  = mk("rate_wrap",   0, 0, 1, 10, 0, 0, 0, 0);
        vt[6]  = mk("rate_c",      0, 0, 1, 10, 0, 0, 1, 0);
        vt[7]  = mk("step_idle",   0, 1, 0, 10, 3, 2, 1, 1);
        vt[8]  = mk("step_p1",     0, 1, 0, 10, 3, 2, 1, 1);
        vt[9]  = mk("step_p2",     0, 1, 0, 10, 3, 2, 1, 1);
        vt[10] = mk("step_p3",     0, 1, 0, 10, 3, 2, 1, 1);
        vt[11] = mk("step_rate",   0, 1, 1, 10, 3, 2, 2, 1);
        vt[12] = mk("rate_d",      0, 0, 1, 10, 2, 2, 3, 0);
        vt[13] = mk("rate_e",      0, 0, 1, 10, 2, 2, 0, 0);
        vt[14] = mk("rate_f",      0, 0, 1, 10, 2, 2, 1, 0);

        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_state", int'(state), 0);
        chk("reset_rate", int'(rate_sel), 1);
        chk("reset_tick", int'(tick), 0);
        rst = 1'b0;
        ticks_seen = 0;
        repeat (50) cycle();
        chk("idle_no_tick", ticks_seen, 0);

        for (int i = 0; i < 15; i++) begin
            k = cyc;
            btn_run = vt[i].r; btn_step = vt[i].s; btn_rate = vt[i].t;
            if (vt[i].tk) exp_q.push_back(k + LAT);
            for (int c = 1; c <= 20; c++) begin
                cycle();
                if (c == vt[i].hold) begin
                    btn_run = 1'b0; btn_step = 1'b0; btn_rate = 1'b0;
                end
                if (c == LAT) begin
                    chk({vt[i].name, "_state"}, int'(state), vt[i].s7);
                    chk({vt[i].name, "_rate"}, int'(rate_sel), vt[i].rate);
                end
                if (c == LAT + 1) chk({vt[i].name, "_state_next"}, int'(state), vt[i].s8);
            end
        end

        // Run from PAUSE with the divider at 0: first tick DIV1 after RUN entry.
        set_chg(K_START, DIV1, DIV1);
        press(1'b1, 1'b0, 1'b0, 2, 1, 1);
        repeat (20) cycle();

        // Step while running is ignored.
        press(1'b0, 1'b1, 1'b0, 1, 1, 1);
        repeat (10) cycle();

        // Rate press landing on a terminal-count edge suppresses that tick.
        bound = 0;
        while (next_tick + period - LAT != cyc && bound < 50) begin
            cycle();
            bound++;
        end
        chk("align_rate_terminal", int'(bound < 50), 1);
        rate_in_run(DIV2, 2);
        rate_in_run(DIV3, 3);
        rate_in_run(DIV0, 0);
        rate_in_run(DIV1, 1);

        // Pause two cycles after a tick, hold off, then resume three cycles from the end.
        bound = 0;
        while (next_tick - cyc != period && bound < 50) begin
            cycle();
            bound++;
        end
        chk("align_pause", int'(bound < 50), 1);
        set_chg(K_STOP, 0, 0);
        press(1'b1, 1'b0, 1'b0, 1, 2, 2);
        ticks_seen = 0;
        repeat (100) cycle();
        chk("pause_no_tick", ticks_seen, 0);
        set_chg(K_START, 3, DIV1);
        press(1'b1, 1'b0, 1'b0, 2, 1, 1);
        repeat (20) cycle();

        // Run and step together from PAUSE: RUN wins, no step tick.
        set_chg(K_STOP, 0, 0);
        press(1'b1, 1'b0, 1'b0, 1, 2, 2);
        repeat (5) cycle();
        set_chg(K_START, remain, DIV1);
        press(1'b1, 1'b1, 1'b0, 2, 1, 1);
        repeat (20) cycle();

        // Reset on the terminal-count edge drops the tick.
        bound = 0;
        while (next_tick - cyc != 1 && bound < 50) begin
            cycle();
            bound++;
        end
        chk("align_reset", int'(bound < 50), 1);
        run_sched = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_tick", int'(tick), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_rate", int'(rate_sel), 1);
        rst = 1'b0;
        ticks_seen = 0;
        repeat (20) cycle();
        chk("post_rst_no_tick", ticks_seen, 0);
        chk("post_rst_state", int'(state), 0);

        chk("ticks_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
